// File: rtl/div_unit.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per cycle, sign fix-up in a final cycle. Remainder -> hi, quotient -> lo.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // -2^(W-1) negates to itself, which is already the right unsigned magnitude
    always_comb begin
        a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag  = divisor[WIDTH-1] ? -divisor : divisor;
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            quo    <= a_mag;
                            dvs    <= b_mag;
                            rem    <= '0;
                            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r <= dividend[WIDTH-1];
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    lo_out <= sign_q ? -quo : quo;
                    hi_out <= sign_r ? -rem : rem;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus random ops through a
// scoreboard queue, with reset, re-pulse and back-to-back corner sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    exp_t sb_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is driven now and taken at the next posedge.
    // Returns at the negedge where done is seen, so a caller may start again
    // immediately in the done cycle.
    task automatic run_op(input string name,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz,
                          input int repulse_at,
                          input logic [31:0] ra, input logic [31:0] rb);
        int   lat;
        int   bcnt;
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb_q.push_back('{hi: ehi, lo: elo, dz: edz});
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (lat == repulse_at) begin
                dividend = ra;
                divisor  = rb;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, lat);
            sb_q.delete();
            return;
        end
        chk({name, " latency"}, 32'(lat), edz ? 32'd0 : 32'd33);
        chk({name, " busy_cycles"}, 32'(bcnt), edz ? 32'd0 : 32'd33);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got done expected none", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, " hi"}, hi_out, e.hi);
        chk({name, " lo"}, lo_out, e.lo);
        chk({name, " div_zero"}, 32'(div_zero), 32'(e.dz));
    endtask

    vec_t vecs[10];

    initial begin
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] rq;
        logic [31:0] rr;

        vecs[0] = '{32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[1] = '{32'd55, 32'd0, 32'd2, 32'd14, 1'b1};
        vecs[2] = '{-32'sd100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
        vecs[3] = '{32'd100, -32'sd7, 32'd2, 32'hFFFFFFF2, 1'b0};
        vecs[4] = '{-32'sd100, -32'sd7, 32'hFFFFFFFE, 32'd14, 1'b0};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
        vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[7] = '{32'd7, 32'd100, 32'd7, 32'd0, 1'b0};
        vecs[8] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0, 1'b0};

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi_out, 32'd0);
        chk("reset lo", lo_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz, -1, '0, '0);

        for (int i = 0; i < 12; i++) begin
            sa = $urandom;
            sb = (i < 6) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i[0]) sb = -sb;
            if (sb == 0) sb = 32'sd3;
            if (sa == 32'sh80000000 && sb == -32'sd1) sb = 32'sd2;
            rq = sa / sb;
            rr = sa % sb;
            run_op($sformatf("rand%0d", i), sa, sb, rr, rq, 1'b0, -1, '0, '0);
        end

        run_op("pre_dz", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, '0, '0);
        @(negedge clk);
        chk("done_clears", 32'(done), 32'd0);
        run_op("dz", 32'd55, 32'd0, 32'd2, 32'd14, 1'b1, -1, '0, '0);
        @(negedge clk);
        chk("dz_one_cycle", 32'(div_zero), 32'd0);

        run_op("repulse", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0,
               4, 32'd9, 32'd3);
        run_op("after_done", 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, -1, '0, '0);
        @(negedge clk);

        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset busy", 32'(busy), 32'd0);
        chk("mid_reset done", 32'(done), 32'd0);
        chk("mid_reset hi", hi_out, 32'd0);
        chk("mid_reset lo", lo_out, 32'd0);
        reset = 1'b1;
        sb_q.delete();
        repeat (40) @(negedge clk);
        chk("no_stale_done hi", hi_out, 32'd0);
        run_op("post_reset", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, '0, '0);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d left expected 0",
                     sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
